// File: rtl/tdm_demux.sv
// tdm_demux: receive side of the serial TDM lane.
// Tracks the channel index of each valid beat, collects one frame into a
// staging register and publishes it on dout in a single update once the last
// channel arrives. Alignment comes from frame_sync on channel 0; any sync
// violation is flagged with a one-cycle sync_err pulse and then recovered.
module tdm_demux #(
  parameter int  CHANNELS = 4,
  parameter int  WIDTH    = 1,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          din,
  input  logic                      din_valid,
  input  logic                      frame_sync,
  output logic [SEL_W-1:0]          sel,
  output logic [CHANNELS*WIDTH-1:0] dout,
  output logic                      dout_valid,
  output logic                      locked,
  output logic                      sync_err
);

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(CHANNELS - 1);
  localparam logic [SEL_W-1:0] ONE_SEL  = SEL_W'(1);

  state_t                          state_q;
  logic [SEL_W-1:0]                sel_q;
  // Channels 0..CHANNELS-2 wait here; the last channel goes straight to dout.
  logic [(CHANNELS-1)*WIDTH-1:0]   staging_q;
  logic [CHANNELS*WIDTH-1:0]       dout_q;
  logic                            dout_valid_q;
  logic                            sync_err_q;

  // Frame tracking FSM: only valid beats advance it; pulses last one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= HUNT;
      sel_q        <= '0;
      staging_q    <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      dout_valid_q <= 1'b0;
      sync_err_q   <= 1'b0;
      if (din_valid) begin
        case (state_q)
          HUNT: begin
            // Unsynced beats are dropped silently while searching.
            if (frame_sync) begin
              staging_q[WIDTH-1:0] <= din;
              sel_q                <= ONE_SEL;
              state_q              <= RUN;
            end
          end
          RUN: begin
            if (frame_sync) begin
              // Sync always restarts the frame; off channel 0 it is an error
              // and the partial frame is abandoned without touching dout.
              if (sel_q != '0) begin
                sync_err_q <= 1'b1;
              end
              staging_q[WIDTH-1:0] <= din;
              sel_q                <= ONE_SEL;
            end else if (sel_q == '0) begin
              // Channel 0 without sync: alignment lost, go back to hunting.
              sync_err_q <= 1'b1;
              sel_q      <= '0;
              state_q    <= HUNT;
            end else if (sel_q == LAST_SEL) begin
              dout_q       <= {din, staging_q};
              dout_valid_q <= 1'b1;
              sel_q        <= '0;
            end else begin
              for (int i = 1; i < CHANNELS - 1; i++) begin
                if (sel_q == SEL_W'(i)) begin
                  staging_q[i*WIDTH +: WIDTH] <= din;
                end
              end
              sel_q <= sel_q + ONE_SEL;
            end
          end
          default: begin
            state_q <= HUNT;
            sel_q   <= '0;
          end
        endcase
      end
    end
  end

  assign sel        = sel_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign locked     = (state_q == RUN);
  assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: directed checks of tdm_demux with a 4x4-bit instance and a
// default-parameter (4x1-bit) instance sharing one clock and reset.
module tb_tdm_demux;

  logic clk;
  logic rst;

  // 4 channels x 4 bits
  logic [3:0]  din4;
  logic        v4;
  logic        fs4;
  logic [1:0]  sel4;
  logic [15:0] dout4;
  logic        dv4;
  logic        lk4;
  logic        se4;

  // default parameters: 4 channels x 1 bit
  logic        din1;
  logic        v1;
  logic        fs1;
  logic [1:0]  sel1;
  logic [3:0]  dout1;
  logic        dv1;
  logic        lk1;
  logic        se1;

  int checks;
  int errors;
  int se_cnt;
  int dv_cnt;
  int both_cnt;

  tdm_demux #(.CHANNELS(4), .WIDTH(4)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .din        (din4),
    .din_valid  (v4),
    .frame_sync (fs4),
    .sel        (sel4),
    .dout       (dout4),
    .dout_valid (dv4),
    .locked     (lk4),
    .sync_err   (se4)
  );

  tdm_demux dut1 (
    .clk        (clk),
    .rst        (rst),
    .din        (din1),
    .din_valid  (v1),
    .frame_sync (fs1),
    .sel        (sel1),
    .dout       (dout1),
    .dout_valid (dv1),
    .locked     (lk1),
    .sync_err   (se1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters for the 4-bit instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      se_cnt   = se_cnt + int'(se4);
      dv_cnt   = dv_cnt + int'(dv4);
      both_cnt = both_cnt + int'(se4 & dv4);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One valid beat on the 4-bit instance; returns 1 time unit after the edge.
  task automatic beat4(input logic [3:0] d, input logic s);
    din4 = d;
    fs4  = s;
    v4   = 1'b1;
    @(posedge clk);
    #1;
    v4  = 1'b0;
    fs4 = 1'b0;
    $display("beat4 din=%h sync=%b -> sel=%0d dout=%h dv=%b lock=%b serr=%b",
             d, s, sel4, dout4, dv4, lk4, se4);
  endtask

  task automatic beat1(input logic d, input logic s);
    din1 = d;
    fs1  = s;
    v1   = 1'b1;
    @(posedge clk);
    #1;
    v1  = 1'b0;
    fs1 = 1'b0;
    $display("beat1 din=%b sync=%b -> sel=%0d dout=%b dv=%b lock=%b",
             d, s, sel1, dout1, dv1, lk1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    se_cnt = 0; dv_cnt = 0; both_cnt = 0;
    din4 = '0; v4 = 1'b0; fs4 = 1'b0;
    din1 = 1'b0; v1 = 1'b0; fs1 = 1'b0;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;

    // Reset state
    check("rst_sel",    32'(sel4),  32'h0);
    check("rst_dout",   32'(dout4), 32'h0);
    check("rst_locked", 32'(lk4),   32'h0);
    check("rst_dv",     32'(dv4),   32'h0);
    check("rst_serr",   32'(se4),   32'h0);

    // Normal frame
    beat4(4'hA, 1'b1);
    check("norm_lock", 32'(lk4),  32'h1);
    check("norm_sel1", 32'(sel4), 32'h1);
    beat4(4'hB, 1'b0);
    beat4(4'hC, 1'b0);
    check("norm_sel3", 32'(sel4), 32'h3);
    check("norm_nodv", 32'(dv4),  32'h0);
    beat4(4'hD, 1'b0);
    check("norm_dout", 32'(dout4), 32'hDCBA);
    check("norm_dv",   32'(dv4),   32'h1);
    check("norm_sel0", 32'(sel4),  32'h0);
    check("norm_lk",   32'(lk4),   32'h1);
    idle(1);
    check("norm_dv_end", 32'(dv4),   32'h0);
    check("norm_hold",   32'(dout4), 32'hDCBA);

    // Gapped frame followed back-to-back by another
    beat4(4'hA, 1'b1);
    beat4(4'hB, 1'b0);
    idle(3);
    check("gap_sel", 32'(sel4), 32'h2);
    beat4(4'hC, 1'b0);
    beat4(4'hD, 1'b0);
    check("gap_dout", 32'(dout4), 32'hDCBA);
    check("gap_dv",   32'(dv4),   32'h1);
    beat4(4'h1, 1'b1);
    check("b2b_dv_low", 32'(dv4),  32'h0);
    check("b2b_sel",    32'(sel4), 32'h1);
    beat4(4'h2, 1'b0);
    beat4(4'h3, 1'b0);
    beat4(4'h4, 1'b0);
    check("b2b_dout", 32'(dout4), 32'h4321);
    check("b2b_dv",   32'(dv4),   32'h1);
    idle(1);
    check("b2b_serr_cnt", 32'(se_cnt), 32'd0);
    check("b2b_dv_cnt",   32'(dv_cnt), 32'd3);

    // Early sync abandons 5,6
    beat4(4'h5, 1'b1);
    beat4(4'h6, 1'b0);
    beat4(4'h7, 1'b1);
    check("early_serr", 32'(se4),   32'h1);
    check("early_lock", 32'(lk4),   32'h1);
    check("early_sel",  32'(sel4),  32'h1);
    check("early_dout", 32'(dout4), 32'h4321);
    check("early_nodv", 32'(dv4),   32'h0);
    beat4(4'h8, 1'b0);
    check("early_serr_end", 32'(se4), 32'h0);
    beat4(4'h9, 1'b0);
    beat4(4'hA, 1'b0);
    check("early_frame", 32'(dout4), 32'hA987);
    idle(1);
    check("early_serr_cnt", 32'(se_cnt), 32'd1);
    check("early_dv_cnt",   32'(dv_cnt), 32'd4);

    // Missing sync drops to HUNT; unsynced beats ignored until relock
    beat4(4'hF, 1'b0);
    check("miss_serr", 32'(se4),   32'h1);
    check("miss_lock", 32'(lk4),   32'h0);
    check("miss_sel",  32'(sel4),  32'h0);
    check("miss_dout", 32'(dout4), 32'hA987);
    beat4(4'h3, 1'b0);
    check("hunt_serr", 32'(se4),  32'h0);
    check("hunt_lock", 32'(lk4),  32'h0);
    check("hunt_sel",  32'(sel4), 32'h0);
    beat4(4'hE, 1'b1);
    check("relock", 32'(lk4), 32'h1);
    beat4(4'h1, 1'b0);
    beat4(4'h2, 1'b0);
    beat4(4'h3, 1'b0);
    check("relock_dout", 32'(dout4), 32'h321E);
    idle(1);
    check("miss_serr_cnt", 32'(se_cnt), 32'd2);
    check("miss_dv_cnt",   32'(dv_cnt), 32'd5);

    // Default-parameter instance: sync with no valid does nothing
    din1 = 1'b1; fs1 = 1'b1; v1 = 1'b0;
    idle(1);
    fs1 = 1'b0;
    check("d1_hunt_lock", 32'(lk1),  32'h0);
    check("d1_hunt_sel",  32'(sel1), 32'h0);
    beat1(1'b1, 1'b1);
    beat1(1'b0, 1'b0);
    beat1(1'b1, 1'b0);
    beat1(1'b1, 1'b0);
    check("d1_dout", 32'(dout1), 32'hD);
    check("d1_dv",   32'(dv1),   32'h1);
    din1 = 1'b0; fs1 = 1'b1; v1 = 1'b0;
    idle(1);
    fs1 = 1'b0;
    check("d1_nv_sel",  32'(sel1),  32'h0);
    check("d1_nv_lock", 32'(lk1),   32'h1);
    check("d1_nv_dout", 32'(dout1), 32'hD);
    check("d1_nv_dv",   32'(dv1),   32'h0);

    // Asynchronous reset with a half-filled frame
    beat4(4'h9, 1'b1);
    beat4(4'h8, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_sel",  32'(sel4),  32'h0);
    check("arst_dout", 32'(dout4), 32'h0);
    check("arst_lock", 32'(lk4),   32'h0);
    check("arst_dv",   32'(dv4),   32'h0);
    check("arst_d1",   32'(dout1), 32'h0);
    idle(1);
    rst = 1'b0;
    beat4(4'h4, 1'b1);
    beat4(4'h3, 1'b0);
    beat4(4'h2, 1'b0);
    beat4(4'h1, 1'b0);
    check("post_rst_dout", 32'(dout4), 32'h1234);
    check("post_rst_dv",   32'(dv4),   32'h1);
    idle(1);
    check("never_both", 32'(both_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Receiving end of the time-division multiplexed link driven by the team's gate-level 2:1 mux chain.
- Accepts one sample per valid beat from a single serial lane, tracks the channel index, and reassembles each frame into parallel registered channel outputs.
- Frame alignment comes from a sync marker on channel 0. Misalignment is detected, flagged and recovered.

Parameters:
- CHANNELS, 4, number of TDM channels per frame; legal range 2..16.
- WIDTH, 1, bits per sample.
- SEL_W, $clog2(CHANNELS), width of the channel index. Derived; must not be overridden.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- din  input  WIDTH  serial sample from the mux lane.
- din_valid  input  1  din holds a sample this cycle.
- frame_sync  input  1  qualifies the current valid sample as channel 0. Ignored when din_valid=0.
- sel  output  SEL_W  channel index expected for the next valid sample. Mirrors the transmitter's select.
- dout  output  CHANNELS*WIDTH  last complete frame; channel i at dout[i*WIDTH +: WIDTH].
- dout_valid  output  1  one-cycle pulse: dout just updated.
- locked  output  1  high in RUN state.
- sync_err  output  1  one-cycle pulse on an alignment violation.

Behaviour:
- Reset (async, immediate): state=HUNT, sel=0, staging register=0, dout=0, dout_valid=0, locked=0, sync_err=0. Reset mid-frame discards the partial frame; dout is also cleared.
- All outputs are registered. Only beats with din_valid=1 advance anything.
- HUNT:
  - din_valid=1 & frame_sync=1: store din in staging[0], sel<=1, go to RUN.
  - din_valid=1 & frame_sync=0: discard the sample, stay in HUNT. No error is raised.
- RUN, with k=sel:
  - din_valid=1, frame_sync=0, 0<k<CHANNELS-1: staging[k]<=din, sel<=k+1.
  - din_valid=1, frame_sync=0, k=CHANNELS-1: dout<={din, staging[CHANNELS-2:0]} on this edge; dout_valid=1 for the next cycle only; sel<=0; stay in RUN.
  - din_valid=1, k=0, frame_sync=1: staging[0]<=din, sel<=1. This is the normal frame start.
  - din_valid=1, k=0, frame_sync=0: missing sync. Pulse sync_err, discard the sample, sel<=0, go to HUNT.
  - din_valid=1, k!=0, frame_sync=1: early sync. Pulse sync_err, drop the partial frame, take din as the new channel 0 (staging[0]<=din), sel<=1, stay in RUN. dout is unchanged and dout_valid is not pulsed.
- din_valid=0: no state change. Gaps of any length inside a frame are allowed.
- Latency: dout/dout_valid are visible 1 cycle after the edge that samples the last channel.
- Back-to-back frames are supported with no idle beat; dout_valid may then pulse every CHANNELS valid cycles.
- dout holds its value between pulses and is never partially updated.
- locked=1 exactly while state=RUN. sync_err and dout_valid are never high in the same cycle.
- sel wraps CHANNELS-1 -> 0 and never exceeds CHANNELS-1.

Test Plan:
- Reset: assert rst asynchronously between edges with a half-filled frame -> sel=0, dout=0, locked=0, dout_valid=0 immediately; the next frame assembles cleanly.
- Normal frame: CHANNELS=4, WIDTH=4; beats 0xA(sync),0xB,0xC,0xD -> one cycle after the 4th edge, dout=16'hDCBA, dout_valid high 1 cycle, sel=0, locked=1.
- Gapped and back-to-back frames: same frame with din_valid low 3 cycles between beats 1 and 2, followed immediately by frame 0x1(sync),0x2,0x3,0x4 -> dout=16'hDCBA, then 16'h4321; two dout_valid pulses, no sync_err.
- Early sync: after 0x5(sync),0x6, send 0x7 with sync, then 0x8,0x9,0xA -> sync_err pulses once, dout=16'hA987, and 0x5/0x6 never appear on dout.
- Missing sync: after a complete frame, send a beat at sel=0 without sync -> sync_err pulse, locked=0, sample dropped. Unsynced beats are then discarded silently until a sync beat relocks.
- Default params (CHANNELS=4, WIDTH=1): alternating sync-framed pattern 1,0,1,1 -> dout=4'b1101; frame_sync asserted with din_valid=0 -> no effect.
